// File: rtl/product_accumulator.sv
// product_accumulator: sums a stream of unsigned products into a wide
// accumulator. A frame ends on a beat marked in_last. The frame sum is then
// held on acc_out until the consumer takes it.
//
// Handshakes (both ports): a transfer happens on a rising clk edge exactly
// when valid && ready are both high. A producer holding valid keeps its data
// stable until the transfer happens. in_ready is low in HOLD and while rst is
// asserted. out_valid is high exactly in HOLD. clear overrides both
// handshakes: a beat presented together with clear is dropped.
module product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  term_count,
  output logic              overflow,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state, state_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               ovf, ovf_n;
  logic [ACC_W:0]     sum_ext;
  logic               accept;

  // One extra bit on the add so that its top bit is the carry-out.
  assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};

  // in_ready is forced low during reset so that nothing can be taken then.
  assign in_ready   = ~rst & (state != HOLD);
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state == HOLD);
  assign acc_out    = acc;
  assign term_count = cnt;
  assign overflow   = ovf;
  assign state_dbg  = state;

  // State register and frame datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
    end
  end

  // Next-state and datapath update. clear has priority, then the result
  // handshake in HOLD, then beat acceptance in IDLE/ACCUM.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf;
    if (clear) begin
      state_n = IDLE;
      acc_n   = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (out_ready) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
          end
        end
        IDLE, ACCUM: begin
          if (accept) begin
            acc_n   = sum_ext[ACC_W-1:0];
            cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            ovf_n   = ovf | sum_ext[ACC_W];
            state_n = in_last ? HOLD : ACCUM;
          end
        end
        default: begin
          state_n = IDLE;
          acc_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed vector table, hand-written corner
// sequences and a randomized run against a sum/count reference model.
module tb_product_accumulator;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PROD_W-1:0] product = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  term_count;
  logic              overflow;
  logic [1:0]        state_dbg;

  product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .product(product),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .term_count(term_count), .overflow(overflow),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [ACC_W-1:0] exp_q[$];

  // Reference model: true (unbounded) frame sum, term count, hold flag.
  longint m_sum   = 0;
  int     m_terms = 0;
  bit     m_hold  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_acc, input logic [31:0] e_cnt,
                         input logic e_ovf, input logic e_valid, input logic e_ready);
    chk({tag, ".acc"},   32'(acc_out),    e_acc);
    chk({tag, ".cnt"},   32'(term_count), e_cnt);
    chk({tag, ".ovf"},   32'(overflow),   32'(e_ovf));
    chk({tag, ".valid"}, 32'(out_valid),  32'(e_valid));
    chk({tag, ".ready"}, 32'(in_ready),   32'(e_ready));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [PROD_W-1:0] p, input logic last);
    in_valid = 1'b1; product = p; in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  function automatic void model_reset();
    m_sum = 0; m_terms = 0; m_hold = 1'b0;
  endfunction

  // Model of one clock edge with the currently driven inputs.
  function automatic void model_edge();
    if (clear) model_reset();
    else if (m_hold) begin
      if (out_ready) model_reset();
    end else if (in_valid) begin
      m_sum += longint'(product);
      m_terms++;
      if (in_last) begin
        m_hold = 1'b1;
        exp_q.push_back(ACC_W'(m_sum));
      end
    end
  endfunction

  task automatic chk_model(input string tag);
    chk_all(tag, 32'(ACC_W'(m_sum)), (m_terms > 255) ? 32'd255 : 32'(m_terms),
            m_sum >= (64'd1 << ACC_W), m_hold, !m_hold);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [PROD_W-1:0] prod;
    logic              last;
    logic [ACC_W-1:0]  e_acc;
    logic [CNT_W-1:0]  e_cnt;
    logic              e_ovf;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{16'h00FF, 1'b0, 24'h0000FF, 8'd1, 1'b0};
    vt[1] = '{16'h0100, 1'b0, 24'h0001FF, 8'd2, 1'b0};
    vt[2] = '{16'h0001, 1'b1, 24'h000200, 8'd3, 1'b0};
    vt[3] = '{16'hFE01, 1'b1, 24'h00FE01, 8'd1, 1'b0};
    vt[4] = '{16'hFFFF, 1'b0, 24'h00FFFF, 8'd1, 1'b0};
    vt[5] = '{16'h0001, 1'b1, 24'h010000, 8'd2, 1'b0};
    vt[6] = '{16'h1234, 1'b0, 24'h001234, 8'd1, 1'b0};
    vt[7] = '{16'h4321, 1'b1, 24'h005555, 8'd2, 1'b0};

    // Reset state, sampled while rst is high.
    #2;
    chk_all("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("reset.release_ready", 32'(in_ready), 32'h1);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      beat(vt[i].prod, vt[i].last);
      chk_all($sformatf("vec%0d", i), 32'(vt[i].e_acc), 32'(vt[i].e_cnt), vt[i].e_ovf,
              vt[i].last, !vt[i].last);
      if (vt[i].last) begin
        drain();
        chk_all($sformatf("vec%0d.drain", i), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      end
    end

    // Result held while consumer stalls; waiting beat not consumed.
    beat(16'h00FF, 1'b0);
    beat(16'h0100, 1'b0);
    beat(16'h0001, 1'b1);
    in_valid = 1'b1; product = 16'h1234; in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_all($sformatf("stall%0d", c), 32'h000200, 32'd3, 1'b0, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_all("stall.release", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    chk_all("stall.taken", 32'h001234, 32'd1, 1'b0, 1'b0, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_all("stall.clear", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // 257 beats of 0xFFFF: wraps and saturates the term counter.
    for (int b = 1; b <= 257; b++) beat(16'hFFFF, b == 257);
    chk_all("long", 32'h00FEFF, 32'd255, 1'b1, 1'b1, 1'b0);
    drain();
    chk_all("long.drain", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // clear beats a simultaneous beat.
    beat(16'h0010, 1'b0);
    beat(16'h0010, 1'b0);
    chk("clr.pre_acc", 32'(acc_out), 32'h20);
    clear = 1'b1; in_valid = 1'b1; product = 16'h0020;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk_all("clr", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    // clear also aborts a held result.
    beat(16'h0003, 1'b1);
    clear = 1'b1; out_ready = 1'b0;
    step();
    clear = 1'b0;
    chk_all("clr.hold", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset between edges.
    beat(16'h0005, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    beat(16'h0005, 1'b0);
    beat(16'h0007, 1'b1);
    chk_all("post_rst", 32'h00000C, 32'd2, 1'b0, 1'b1, 1'b0);
    drain();

    // Randomized traffic against the reference model.
    model_reset();
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      clear     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      product   = PROD_W'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      if (m_hold && (clear || out_ready)) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rand.queue: empty expected queue at cycle %0d", c);
        end else begin
          logic [ACC_W-1:0] e;
          e = exp_q.pop_front();
          if (!clear) chk($sformatf("rand.result%0d", c), 32'(acc_out), 32'(e));
        end
      end
      model_edge();
      step();
      chk_model($sformatf("rand%0d", c));
    end
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
